dram_cmd_sequencer: RTL and testbench
=====================================

// Module: dram_cmd_sequencer
// PURPOSE
//  Downstream of the 16-entry request queue. Pops one request at a time and
//  issues the DDR5 closed-page command sequence on dimm_clk:
//  ACT0/ACT1, then RD0/RD1 or WR0/WR1, then PRE.
//  Enforces tRCD, tCL+tBURST and the same-bank tRP gap. One request in flight.
// PARAMETERS
//  TRCD    39  dimm_clk cycles from ACT0 to RD0/WR0 (>=2)
//  TCL     40  CAS latency, dimm_clk cycles
//  TBURST  8   burst length, dimm_clk cycles; RD0/WR0 to PRE = TCL+TBURST (>=2)
//  TRP     39  dimm_clk cycles from PRE to next ACT0 on the same {bg,bank} (>=1)
//  CNT_W   8   timing counter width; every timing value must be < 2**CNT_W
// PORTS
//  dimm_clk     in   1   DIMM clock; the only clock
//  rst          in   1   asynchronous reset, active-high
//  req_valid    in   1   queue head valid
//  req_ready    out  1   sequencer accepts head this cycle
//  req_op       in   2   0=read, 1=write, 2=fetch (issued as read), 3=illegal
//  req_core     in   4   originating core, echoed on cmd_core
//  req_addr     in   34  [1:0]byte [5:2]col_l [6]chan [9:7]bg [11:10]bank [17:12]col_h [33:18]row
//  cmd_valid    out  1   cmd_code != NOP
//  cmd_code     out  3   0 NOP,1 ACT0,2 ACT1,3 RD0,4 RD1,5 WR0,6 WR1,7 PRE
//  cmd_channel  out  1   addr[6] of the active request
//  cmd_bg       out  3   bank group
//  cmd_bank     out  2   bank
//  cmd_row      out  16  row; meaningful on ACT0/ACT1
//  cmd_col      out  10  {col_h,col_l}; meaningful on RD*/WR*
//  cmd_core     out  4   core of the active request
//  busy         out  1   state != IDLE
//  err_op       out  1   one-cycle pulse when an op==3 request is accepted
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0, except
//    req_ready, which is 1.
//  - The handshake completes on req_valid & req_ready. req_ready=1 only in IDLE.
//    Request fields are captured on acceptance.
//  - Illegal op: accepted, err_op=1 on the following cycle, no commands issued,
//    FSM stays IDLE.
//  - FSM: IDLE -> [WAIT_RP] -> ACT0 -> ACT1 -> WAIT_RCD -> CAS0 -> CAS1
//    -> WAIT_PRE -> PRE -> IDLE. Each command state lasts exactly one cycle.
//  - Timing (A = ACT0 cycle): ACT1 at A+1; RD0/WR0 at A+TRCD; RD1/WR1 at
//    A+TRCD+1; PRE at A+TRCD+TCL+TBURST; IDLE (ready=1) on the cycle after PRE.
//  - Accept at cycle t: ACT0 at t+1 normally.
//  - Same-bank stall: ACT0 at max(t+1, P+TRP) when {bg,bank} equals the last
//    precharged bank and P is that PRE cycle. Channel is ignored in the compare.
//    WAIT_RP holds until then.
//  - Last-bank record is written in the PRE state and cleared by reset. After
//    reset no tRP stall applies.
//  - Counters load on state entry and count down. Counters saturate at 0 and
//    never wrap.
//  - cmd_* address fields hold the last request's values while IDLE. Only
//    cmd_code/cmd_valid return to 0 after PRE.
//  - Reset mid-sequence: asynchronous return to IDLE, cmd_valid=0 immediately.
//    The in-flight request is lost and no PRE is issued.
//  - req_valid deasserted in IDLE: stay IDLE, cmd_code=NOP.
// CONFIGURATION
//  DRAM_SEQ_STATS_EN defined adds outputs stat_rd, stat_wr, stat_fetch,
//  stat_rp_stall (each 32 bit, reset 0, saturating).
//  - stat_rd, stat_wr, stat_fetch increment on acceptance of op 0/1/2.
//  - stat_rp_stall increments on every WAIT_RP cycle.
//  Without the macro these ports and counters do not exist. Command timing is
//  identical either way.
// TESTING
//  1 read bg=2 bank=1 row=0x1A2B, accepted cycle 0 -> ACT0@1, ACT1@2, RD0@40,
//    RD1@41, PRE@88, req_ready=1@89.
//  2 write, then same-bank read accepted @89 -> WR0/WR1 in the first sequence;
//    second ACT0@127 (PRE 88 + TRP 39), 37 WAIT_RP cycles.
//  3 read, then read to bg=3 bank=0 accepted @89 -> second ACT0@90, no stall.
//  4 fetch (op=2) -> RD0/RD1 codes (3,4); op=3 -> err_op pulse, no cmd,
//    req_ready stays 1.
//  5 rst asserted at cycle 50 of a read -> all outputs reset same cycle; next
//    request to the same bank gets ACT0 at accept+1.
//  6 with DRAM_SEQ_STATS_EN: scenarios 1-2 -> stat_rd=1, stat_wr=1,
//    stat_rp_stall=37.

Source files
------------

// File: rtl/dram_cmd_sequencer_if.sv
// rtl/dram_cmd_sequencer_if.sv - request queue head and DIMM command bus for the command sequencer
interface dram_cmd_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_core;
    logic [33:0] req_addr;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic        cmd_channel;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [3:0]  cmd_core;
    logic        busy;
    logic        err_op;

    modport master (
        output req_valid, req_op, req_core, req_addr,
        input  req_ready, cmd_valid, cmd_code, cmd_channel, cmd_bg, cmd_bank,
               cmd_row, cmd_col, cmd_core, busy, err_op
    );

    modport slave (
        input  req_valid, req_op, req_core, req_addr,
        output req_ready, cmd_valid, cmd_code, cmd_channel, cmd_bg, cmd_bank,
               cmd_row, cmd_col, cmd_core, busy, err_op
    );
endinterface

// File: rtl/dram_cmd_sequencer.sv
// rtl/dram_cmd_sequencer.sv - DDR5 closed-page ACT/CAS/PRE sequencer; DRAM_SEQ_STATS_EN adds request/stall counters
module dram_cmd_sequencer #(
    parameter int TRCD   = 39,
    parameter int TCL    = 40,
    parameter int TBURST = 8,
    parameter int TRP    = 39,
    parameter int CNT_W  = 8
) (
    input  logic                  dimm_clk,
    input  logic                  rst,
    dram_cmd_sequencer_if.slave   bus
`ifdef DRAM_SEQ_STATS_EN
    ,
    output logic [31:0]           stat_rd,
    output logic [31:0]           stat_wr,
    output logic [31:0]           stat_fetch,
    output logic [31:0]           stat_rp_stall
`endif
);
    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_RP, S_ACT0, S_ACT1, S_WAIT_RCD,
        S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE
    } state_t;

    localparam logic [2:0] C_NOP = 3'd0, C_ACT0 = 3'd1, C_ACT1 = 3'd2, C_RD0 = 3'd3,
                           C_RD1 = 3'd4, C_WR0 = 3'd5, C_WR1 = 3'd6, C_PRE = 3'd7;

    // Wait-state counters hold "cycles left after this one", hence the -3.
    localparam int RCD_WAIT = (TRCD > 2) ? TRCD - 3 : 0;
    localparam int PRE_WAIT = (TCL + TBURST > 2) ? TCL + TBURST - 3 : 0;
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(RCD_WAIT);
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_WAIT);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] rp_cnt;
    logic [4:0]       last_bank;
    logic             last_valid;
    logic             cur_write;
    logic             wr_next;
    logic             accept;
    logic             rp_hit;
    logic [2:0]       code_next;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[1:0];

    assign accept = bus.req_valid && bus.req_ready;
    // rp_cnt is the distance to the first cycle an ACT0 may follow the last PRE.
    assign rp_hit = last_valid && (last_bank == {bus.req_addr[9:7], bus.req_addr[11:10]})
                    && (rp_cnt > CNT_ONE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_next    = cur_write;
        case (state)
            S_IDLE: begin
                if (accept && bus.req_op != 2'd3) begin
                    wr_next    = (bus.req_op == 2'd1);
                    state_next = rp_hit ? S_WAIT_RP : S_ACT0;
                end
            end
            S_WAIT_RP:  if (rp_cnt <= CNT_ONE) state_next = S_ACT0;
            S_ACT0:     state_next = S_ACT1;
            S_ACT1: begin
                if (TRCD > 2) begin
                    state_next = S_WAIT_RCD;
                    cnt_next   = RCD_LOAD;
                end else begin
                    state_next = S_CAS0;
                end
            end
            S_WAIT_RCD: begin
                if (cnt == '0) state_next = S_CAS0;
                else           cnt_next   = cnt - CNT_ONE;
            end
            S_CAS0:     state_next = S_CAS1;
            S_CAS1: begin
                if (TCL + TBURST > 2) begin
                    state_next = S_WAIT_PRE;
                    cnt_next   = PRE_LOAD;
                end else begin
                    state_next = S_PRE;
                end
            end
            S_WAIT_PRE: begin
                if (cnt == '0) state_next = S_PRE;
                else           cnt_next   = cnt - CNT_ONE;
            end
            S_PRE:      state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        code_next = C_NOP;
        case (state_next)
            S_ACT0:  code_next = C_ACT0;
            S_ACT1:  code_next = C_ACT1;
            S_CAS0:  code_next = wr_next ? C_WR0 : C_RD0;
            S_CAS1:  code_next = wr_next ? C_WR1 : C_RD1;
            S_PRE:   code_next = C_PRE;
            default: code_next = C_NOP;
        endcase
    end

    always_ff @(posedge dimm_clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            rp_cnt          <= '0;
            last_bank       <= '0;
            last_valid      <= 1'b0;
            cur_write       <= 1'b0;
            bus.req_ready   <= 1'b1;
            bus.cmd_valid   <= 1'b0;
            bus.cmd_code    <= C_NOP;
            bus.cmd_channel <= 1'b0;
            bus.cmd_bg      <= '0;
            bus.cmd_bank    <= '0;
            bus.cmd_row     <= '0;
            bus.cmd_col     <= '0;
            bus.cmd_core    <= '0;
            bus.busy        <= 1'b0;
            bus.err_op      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cur_write <= wr_next;
            if (state == S_PRE) begin
                last_bank  <= {bus.cmd_bg, bus.cmd_bank};
                last_valid <= 1'b1;
                rp_cnt     <= RP_LOAD;
            end else if (rp_cnt != '0) begin
                rp_cnt <= rp_cnt - CNT_ONE;
            end
            if (accept) begin
                bus.cmd_channel <= bus.req_addr[6];
                bus.cmd_bg      <= bus.req_addr[9:7];
                bus.cmd_bank    <= bus.req_addr[11:10];
                bus.cmd_row     <= bus.req_addr[33:18];
                bus.cmd_col     <= {bus.req_addr[17:12], bus.req_addr[5:2]};
                bus.cmd_core    <= bus.req_core;
            end
            bus.req_ready <= (state_next == S_IDLE);
            bus.busy      <= (state_next != S_IDLE);
            bus.cmd_code  <= code_next;
            bus.cmd_valid <= (code_next != C_NOP);
            bus.err_op    <= accept && (bus.req_op == 2'd3);
        end
    end

`ifdef DRAM_SEQ_STATS_EN
    always_ff @(posedge dimm_clk or posedge rst) begin
        if (rst) begin
            stat_rd       <= '0;
            stat_wr       <= '0;
            stat_fetch    <= '0;
            stat_rp_stall <= '0;
        end else begin
            if (accept && bus.req_op == 2'd0 && stat_rd != '1)    stat_rd    <= stat_rd + 32'd1;
            if (accept && bus.req_op == 2'd1 && stat_wr != '1)    stat_wr    <= stat_wr + 32'd1;
            if (accept && bus.req_op == 2'd2 && stat_fetch != '1) stat_fetch <= stat_fetch + 32'd1;
            if (state == S_WAIT_RP && stat_rp_stall != '1)        stat_rp_stall <= stat_rp_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb/tb_dram_cmd_sequencer.sv - directed bench for dram_cmd_sequencer (timing, stall, illegal op, reset, stats)
module tb_dram_cmd_sequencer;
    logic dimm_clk = 1'b0;
    logic rst = 1'b1;
    always #5 dimm_clk = ~dimm_clk;

    dram_cmd_sequencer_if bus();
`ifdef DRAM_SEQ_STATS_EN
    logic [31:0] stat_rd, stat_wr, stat_fetch, stat_rp_stall;
`endif

    dram_cmd_sequencer dut (
        .dimm_clk(dimm_clk),
        .rst(rst),
        .bus(bus)
`ifdef DRAM_SEQ_STATS_EN
        ,
        .stat_rd(stat_rd),
        .stat_wr(stat_wr),
        .stat_fetch(stat_fetch),
        .stat_rp_stall(stat_rp_stall)
`endif
    );

    int total = 0;
    int bad = 0;
    int ev[8];
    int rdy_at;
    logic        err_seen;
    logic [15:0] act_row;
    logic [2:0]  act_bg;
    logic [1:0]  act_bank;
    logic        act_chan;
    logic [9:0]  cas_col;
    logic [3:0]  cas_core;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] mk_addr(input logic [2:0] bg, input logic [1:0] bank,
                                            input logic [15:0] row, input logic [9:0] col,
                                            input logic chan);
        return {row, col[9:4], bank, bg, chan, col[3:0], 2'b01};
    endfunction

    // Present one request at a negedge and log the first cycle (relative to accept) of each command.
    task automatic do_req(input logic [1:0] op, input logic [33:0] addr, input logic [3:0] core);
        int k;
        for (int i = 0; i < 8; i++) ev[i] = -1;
        rdy_at = -1;
        err_seen = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_core  = core;
        @(negedge dimm_clk);
        bus.req_valid = 1'b0;
        k = 1;
        while (k < 300 && rdy_at < 0) begin
            if (bus.err_op) err_seen = 1'b1;
            if (bus.cmd_code != 3'd0 && ev[bus.cmd_code] < 0) begin
                ev[bus.cmd_code] = k;
                if (bus.cmd_code == 3'd1) begin
                    act_row  = bus.cmd_row;
                    act_bg   = bus.cmd_bg;
                    act_bank = bus.cmd_bank;
                    act_chan = bus.cmd_channel;
                end
                if (bus.cmd_code == 3'd3 || bus.cmd_code == 3'd5) begin
                    cas_col  = bus.cmd_col;
                    cas_core = bus.cmd_core;
                end
            end
            if (bus.req_ready) rdy_at = k;
            else begin
                @(negedge dimm_clk);
                k++;
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = '0;
        bus.req_core  = '0;
        repeat (3) @(negedge dimm_clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cmd_code", bus.cmd_code, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err_op", bus.err_op, 0);
        chk("rst_cmd_row", bus.cmd_row, 0);
`ifdef DRAM_SEQ_STATS_EN
        chk("rst_stat_rd", stat_rd, 0);
        chk("rst_stat_rp_stall", stat_rp_stall, 0);
`endif
        rst = 1'b0;
        @(negedge dimm_clk);
        chk("idle_no_req_code", bus.cmd_code, 0);
        chk("idle_no_req_busy", bus.busy, 0);

        // Write to bg2/bank1 from a fresh reset: no tRP stall.
        do_req(2'd1, mk_addr(3'd2, 2'd1, 16'h1A2B, 10'h2C5, 1'b1), 4'd5);
        chk("w_act0", ev[1], 1);
        chk("w_act1", ev[2], 2);
        chk("w_wr0", ev[5], 40);
        chk("w_wr1", ev[6], 41);
        chk("w_pre", ev[7], 88);
        chk("w_ready", rdy_at, 89);
        chk("w_no_rd0", ev[3], -1);
        chk("w_row", act_row, 16'h1A2B);
        chk("w_bg", act_bg, 2);
        chk("w_bank", act_bank, 1);
        chk("w_chan", act_chan, 1);
        chk("w_col", cas_col, 10'h2C5);
        chk("w_core", cas_core, 5);
        chk("w_idle_code", bus.cmd_valid, 0);
        chk("w_hold_bg", bus.cmd_bg, 2);
        chk("w_hold_row", bus.cmd_row, 16'h1A2B);

        // Same-bank read accepted the cycle after PRE: ACT0 waits for PRE+TRP.
        do_req(2'd0, mk_addr(3'd2, 2'd1, 16'h0F0F, 10'h013, 1'b0), 4'd9);
        chk("rp_act0", ev[1], 38);
        chk("rp_act1", ev[2], 39);
        chk("rp_rd0", ev[3], 77);
        chk("rp_rd1", ev[4], 78);
        chk("rp_pre", ev[7], 125);
        chk("rp_ready", rdy_at, 126);
        chk("rp_no_wr0", ev[5], -1);
        chk("rp_row", act_row, 16'h0F0F);
        chk("rp_col", cas_col, 10'h013);
`ifdef DRAM_SEQ_STATS_EN
        chk("st_rd", stat_rd, 1);
        chk("st_wr", stat_wr, 1);
        chk("st_fetch", stat_fetch, 0);
        chk("st_rp_stall", stat_rp_stall, 37);
`endif

        // Different bank right after PRE: no stall.
        do_req(2'd0, mk_addr(3'd3, 2'd0, 16'hBEEF, 10'h3FF, 1'b1), 4'd2);
        chk("nb_act0", ev[1], 1);
        chk("nb_rd0", ev[3], 40);
        chk("nb_pre", ev[7], 88);
        chk("nb_ready", rdy_at, 89);
        chk("nb_bg", act_bg, 3);
        chk("nb_col", cas_col, 10'h3FF);

        // Fetch is issued as a read.
        do_req(2'd2, mk_addr(3'd0, 2'd2, 16'h0001, 10'h000, 1'b0), 4'd15);
        chk("f_act0", ev[1], 1);
        chk("f_rd0", ev[3], 40);
        chk("f_rd1", ev[4], 41);
        chk("f_no_wr0", ev[5], -1);
        chk("f_core", cas_core, 15);

        // Illegal op: one-cycle err_op, no commands, ready stays high.
        do_req(2'd3, mk_addr(3'd5, 2'd3, 16'h1234, 10'h055, 1'b0), 4'd1);
        chk("il_err", err_seen, 1);
        chk("il_ready", rdy_at, 1);
        chk("il_no_act0", ev[1], -1);
        chk("il_busy", bus.busy, 0);
        @(negedge dimm_clk);
        chk("il_err_pulse_end", bus.err_op, 0);
        chk("il_code", bus.cmd_code, 0);
`ifdef DRAM_SEQ_STATS_EN
        chk("st_rd2", stat_rd, 2);
        chk("st_fetch1", stat_fetch, 1);
`endif

        // Reset in the middle of a read, then the same bank again.
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_addr  = mk_addr(3'd1, 2'd3, 16'hCAFE, 10'h101, 1'b1);
        bus.req_core  = 4'd7;
        @(negedge dimm_clk);
        bus.req_valid = 1'b0;
        repeat (49) @(negedge dimm_clk);
        chk("mid_busy", bus.busy, 1);
        chk("mid_bg", bus.cmd_bg, 1);
        rst = 1'b1;
        #1;
        chk("ar_cmd_valid", bus.cmd_valid, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_ready", bus.req_ready, 1);
        chk("ar_bg", bus.cmd_bg, 0);
        @(negedge dimm_clk);
        rst = 1'b0;
        do_req(2'd0, mk_addr(3'd1, 2'd3, 16'hCAFE, 10'h101, 1'b1), 4'd7);
        chk("ar2_act0", ev[1], 1);
        chk("ar2_rd0", ev[3], 40);
        chk("ar2_ready", rdy_at, 89);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
